tach_scan_controller: RTL

Time-multiplexed tachometer scheduler. It shares one pulse-counting window engine among `NUM_CH` encoder inputs, scanning them round-robin. For each channel it runs a settle interval, then a fixed gate window, then delivers `{channel, count}` to the register/PID consumer over a valid/ready handshake. It sits between the raw encoder pins and the speed-control software interface.

---
 rtl/tach_pkg.sv | 8 +
 rtl/tach_edge_sync.sv | 24 ++
 rtl/tach_scan_controller.sv | 98 +++++++++
 3 files changed

// File: rtl/tach_pkg.sv
// tach_pkg: shared state type, count width and channel-index width helper for the tachometer scanner
package tach_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, PUBLISH} tach_state_t;
  localparam int COUNT_W = 32;
  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tach_edge_sync.sv
// tach_edge_sync: per-bit 2-flop synchronizer followed by a registered rising-edge pulse
module tach_edge_sync #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         system_reset,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] pulse
);
  logic [W-1:0] s1, s2, prev;
  always_ff @(posedge clock) begin
    if (system_reset) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      pulse <= '0;
    end else begin
      s1    <= async_in;
      s2    <= s1;
      prev  <= s2;
      pulse <= s2 & ~prev;
    end
  end
endmodule

// File: rtl/tach_scan_controller.sv
// tach_scan_controller: round-robin settle/gate/publish tachometer scheduler; define TACH_CHANNEL_MASK_EN to add a channel_mask input
module tach_scan_controller import tach_pkg::*; #(
  parameter int NUM_CH        = 4,
  parameter int CLOCK_FREQ    = 100000000,
  parameter int WINDOW_HZ     = 1000,
  parameter int SETTLE_CLOCKS = 16
) (
  input  logic                        clock,
  input  logic                        system_reset,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           encoder_in,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [ch_width(NUM_CH)-1:0] result_channel,
  output logic [COUNT_W-1:0]          result_count,
  output logic                        busy,
  output logic                        scan_done
`ifdef TACH_CHANNEL_MASK_EN
  ,
  input  logic [NUM_CH-1:0]           channel_mask
`endif
);
  localparam int CH_W       = ch_width(NUM_CH);
  localparam int NUM_CLOCKS = CLOCK_FREQ / WINDOW_HZ;
  tach_state_t state, state_n;
  logic [CH_W-1:0] ptr, ptr_n;
  logic [31:0] timer;
  logic [COUNT_W-1:0] cnt;
  logic [NUM_CH-1:0] pulse, mask;
  logic hit, any, wrap;
`ifdef TACH_CHANNEL_MASK_EN
  assign mask = channel_mask;
`else
  assign mask = '1;
`endif
  assign hit = pulse[ptr];
  assign any = |mask;
  tach_edge_sync #(.W(NUM_CH)) u_sync (
    .clock       (clock),
    .system_reset(system_reset),
    .async_in    (encoder_in),
    .pulse       (pulse)
  );
  function automatic logic [CH_W-1:0] pick(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] p, input int skip);
    logic [CH_W-1:0] r;
    int idx;
    r = p;
    for (int o = NUM_CH - 1; o >= 0; o--) begin
      idx = (int'(p) + o + skip) % NUM_CH;
      if (m[idx[CH_W-1:0]]) r = idx[CH_W-1:0];
    end
    return r;
  endfunction
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    wrap    = 1'b0;
    case (state)
      IDLE: begin
        state_n = (enable && any) ? SETTLE : IDLE;
        ptr_n   = (enable && any) ? pick(mask, ptr, 0) : ptr;
      end
      SETTLE:  state_n = !enable ? IDLE : (timer == 32'(SETTLE_CLOCKS - 1)) ? COUNT : SETTLE;
      COUNT:   state_n = !enable ? IDLE : (timer == 32'(NUM_CLOCKS - 1)) ? PUBLISH : COUNT;
      PUBLISH: begin
        ptr_n   = (result_ready && any) ? pick(mask, ptr, 1) : ptr;
        wrap    = result_ready && any && (ptr_n <= ptr);
        state_n = !result_ready ? PUBLISH : (enable && any) ? SETTLE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (system_reset) begin
      state          <= IDLE;
      ptr            <= '0;
      timer          <= '0;
      cnt            <= '0;
      result_valid   <= 1'b0;
      result_channel <= '0;
      result_count   <= '0;
      busy           <= 1'b0;
      scan_done      <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      timer        <= (state_n != state) ? '0 : timer + 32'd1;
      cnt          <= (state == COUNT) ? cnt + COUNT_W'(hit) : '0;
      result_valid <= state_n == PUBLISH;
      busy         <= state_n != IDLE;
      scan_done    <= wrap;
      if (state == COUNT && state_n == PUBLISH) begin
        result_channel <= ptr;
        result_count   <= cnt + COUNT_W'(hit);
      end
    end
  end
endmodule
